pc_stack_unit: RTL and testbench
================================

// Module: pc_stack_unit
// PURPOSE
//  Parametrised program counter for the tiny RISC CPU; successor to the 6-bit load/inc/clr PC.
//  Adds relative branch, stall, and a hardware return-address stack for call/return.
//  Sits between the control unit and the instruction-memory address port.
//  data_out drives the fetch address directly.
// PARAMETERS
//  AW          6   address width in bits; data_out, data_in and offset are all AW bits
//  DEPTH       4   return-stack entries, >=2; depth counter is $clog2(DEPTH+1) bits
//  RESET_ADDR  0   value loaded into the PC on clr
// PORTS
//  clk          in   1         rising-edge clock
//  clr          in   1         synchronous active-high reset
//  stall        in   1         freeze all state; overrides every control except clr
//  load         in   1         absolute jump: PC <= data_in
//  inc          in   1         sequential step: PC <= PC+1
//  branch       in   1         relative jump: PC <= PC+offset
//  call         in   1         push PC+1, then PC <= data_in
//  ret          in   1         pop: PC <= top of stack
//  data_in      in   AW        absolute target for load/call
//  offset       in   AW        two's-complement branch displacement
//  data_out     out  AW        current PC (registered)
//  depth        out  clog2(DEPTH+1)  number of valid stack entries
//  stack_full   out  1         depth==DEPTH (combinational from depth)
//  stack_empty  out  1         depth==0 (combinational from depth)
//  ovf_err      out  1         sticky: call attempted while full
//  unf_err      out  1         sticky: ret attempted while empty
// BEHAVIOUR
//  - All state updates on posedge clk. data_out changes 1 cycle after the controlling edge.
//  - Reset (clr=1): data_out=RESET_ADDR, depth=0, ovf_err=0, unf_err=0.
//    Stack RAM is not cleared. clr beats every other input, including a mid-call or mid-stall cycle.
//  - Priority when several controls are high:
//    clr > stall > load > call > ret > branch > inc > hold.
//    Exactly one action per cycle; lower-priority requests are dropped, not queued.
//  - stall=1: PC, depth, stack contents and error flags all hold.
//  - load: PC <= data_in; stack untouched.
//  - call, not full: stack[depth] <= PC+1 (mod 2^AW); depth++; PC <= data_in.
//  - call, full: no push, PC holds, ovf_err <= 1.
//  - ret, not empty: PC <= stack[depth-1]; depth--.
//  - ret, empty: PC holds, unf_err <= 1.
//  - branch: PC <= PC + offset, computed mod 2^AW (sign handled by wrap).
//  - inc: PC <= PC+1 mod 2^AW; 2^AW-1 wraps to 0.
//  - No control active: PC holds.
//  - Error flags are sticky until clr; they do not block later valid calls or rets.
//  - LIFO order is strict. Nested call depth up to DEPTH returns addresses in reverse push order.
//  - All arithmetic is AW bits wide; carries out are discarded; no flags on PC wrap.
// TESTING (AW=6, DEPTH=4, RESET_ADDR=0)
//  1 clr=1 for 1 clk, then inc x3 -> data_out 0,1,2,3; depth=0; stack_empty=1
//  2 load data_in=62, then inc x2 -> 62,63,0 (wrap); load+inc same cycle -> load wins
//  3 PC=10: branch offset=6'h3C (-4) -> 6; branch offset=5 -> 11; PC=60 offset=8 -> 4
//  4 PC=5: call 20, call 30, ret, ret -> 20,30,21,6; depth 1,2,1,0
//  5 4 calls fill stack (stack_full=1); 5th call -> PC holds, ovf_err=1;
//    ret on empty -> PC holds, unf_err=1; both flags cleared only by clr
//  6 stall=1 with inc/call/ret active for 3 cycles -> data_out and depth frozen;
//    clr during stall -> PC=0, depth=0

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Program counter for the tiny RISC CPU with relative branch, stall and a
//   hardware return-address stack for call/return. data_out is the fetch
//   address and is fully registered.
//
// Ports
//   clk          rising-edge clock
//   clr          synchronous active-high reset (beats every other control)
//   stall        freeze PC, stack depth, stack contents and error flags
//   load         PC <= data_in
//   inc          PC <= PC + 1
//   branch       PC <= PC + offset (two's-complement, wraps mod 2^AW)
//   call         push PC + 1, then PC <= data_in
//   ret          PC <= top of stack, pop
//   data_in      absolute target for load / call
//   offset       branch displacement
//   data_out     current PC
//   depth        number of valid return-stack entries
//   stack_full   depth == DEPTH
//   stack_empty  depth == 0
//   ovf_err      sticky: call attempted while full
//   unf_err      sticky: ret attempted while empty
//
// Control priority: clr > stall > load > call > ret > branch > inc > hold.
// Exactly one action is taken per cycle; lower-priority requests are dropped.

module pc_stack_unit #(
  parameter int              AW         = 6,
  parameter int              DEPTH      = 4,
  parameter logic [AW-1:0]   RESET_ADDR = '0,
  localparam int             DW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          stall,
  input  logic          load,
  input  logic          inc,
  input  logic          branch,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] data_in,
  input  logic [AW-1:0] offset,
  output logic [AW-1:0] data_out,
  output logic [DW-1:0] depth,
  output logic          stack_full,
  output logic          stack_empty,
  output logic          ovf_err,
  output logic          unf_err
);

  // Stack index only needs to address DEPTH entries; depth itself needs one
  // more code point to represent "full".
  localparam int            IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] FULL_D = DW'(DEPTH);

  // Action chosen this cycle after priority resolution (clr handled in the
  // register process since it also resets the flags).
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_PUSH,
    ACT_OVF,
    ACT_POP,
    ACT_UNF,
    ACT_BRANCH,
    ACT_INC
  } action_t;

  action_t       act;
  logic [AW-1:0] stack [DEPTH];
  logic [IW-1:0] push_idx;
  logic [IW-1:0] pop_idx;
  logic [AW-1:0] pop_data;

  assign stack_full  = (depth == FULL_D);
  assign stack_empty = (depth == '0);

  // push writes slot depth; pop reads slot depth-1. Both are only used when
  // the respective full/empty guard allows, so they stay in range.
  assign push_idx = depth[IW-1:0];
  assign pop_idx  = IW'(depth - DW'(1));
  assign pop_data = stack[pop_idx];

  always_comb begin
    act = ACT_HOLD;
    if (stall)       act = ACT_HOLD;
    else if (load)   act = ACT_LOAD;
    else if (call)   act = stack_full  ? ACT_OVF : ACT_PUSH;
    else if (ret)    act = stack_empty ? ACT_UNF : ACT_POP;
    else if (branch) act = ACT_BRANCH;
    else if (inc)    act = ACT_INC;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_out <= RESET_ADDR;
      depth    <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else begin
      case (act)
        ACT_HOLD:   ;
        ACT_LOAD:   data_out <= data_in;
        ACT_PUSH: begin
          data_out <= data_in;
          depth    <= depth + DW'(1);
        end
        ACT_OVF:    ovf_err <= 1'b1;
        ACT_POP: begin
          data_out <= pop_data;
          depth    <= depth - DW'(1);
        end
        ACT_UNF:    unf_err <= 1'b1;
        ACT_BRANCH: data_out <= data_out + offset;
        ACT_INC:    data_out <= data_out + AW'(1);
        default:    ;
      endcase
    end
  end

  // Stack storage has no reset; clr only empties it logically via depth.
  always_ff @(posedge clk) begin
    if (!clr && act == ACT_PUSH) begin
      stack[push_idx] <= data_out + AW'(1);
    end
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit
//   Directed scenarios with hand-computed expectations, followed by a long
//   randomized run. A behavioural model (integer PC plus a queue used as the
//   return stack) tracks what the outputs must be; one compare process checks
//   every output against it on each falling edge once reset has been seen.

module tb_pc_stack_unit;

  localparam int AW    = 6;
  localparam int DEPTH = 4;
  localparam int DW    = 3;
  localparam int MODV  = 1 << AW;

  // control vector bit order {clr, stall, load, call, ret, branch, inc}
  localparam logic [6:0] C_NONE   = 7'b0000000;
  localparam logic [6:0] C_CLR    = 7'b1000000;
  localparam logic [6:0] C_STALL  = 7'b0100000;
  localparam logic [6:0] C_LOAD   = 7'b0010000;
  localparam logic [6:0] C_CALL   = 7'b0001000;
  localparam logic [6:0] C_RET    = 7'b0000100;
  localparam logic [6:0] C_BRANCH = 7'b0000010;
  localparam logic [6:0] C_INC    = 7'b0000001;

  logic          clk = 1'b0;
  logic          clr = 1'b0, stall = 1'b0, load = 1'b0, inc = 1'b0;
  logic          branch = 1'b0, call = 1'b0, ret = 1'b0;
  logic [AW-1:0] data_in = '0, offset = '0;
  logic [AW-1:0] data_out;
  logic [DW-1:0] depth;
  logic          stack_full, stack_empty, ovf_err, unf_err;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  pc_stack_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_ADDR('0)) dut (
    .clk(clk), .clr(clr), .stall(stall), .load(load), .inc(inc),
    .branch(branch), .call(call), .ret(ret), .data_in(data_in),
    .offset(offset), .data_out(data_out), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .ovf_err(ovf_err), .unf_err(unf_err)
  );

  // ---------------- behavioural model ----------------
  bit m_valid = 1'b0;
  int m_pc    = 0;
  int m_ovf   = 0;
  int m_unf   = 0;
  logic [AW-1:0] exp_q[$];   // return-address stack, back = top

  always @(posedge clk) begin
    if (clr) begin
      m_valid = 1'b1;
      m_pc    = 0;
      m_ovf   = 0;
      m_unf   = 0;
      exp_q.delete();
    end else if (stall) begin
      // everything holds
    end else if (load) begin
      m_pc = int'(data_in);
    end else if (call) begin
      if (exp_q.size() == DEPTH) m_ovf = 1;
      else begin
        exp_q.push_back(AW'((m_pc + 1) % MODV));
        m_pc = int'(data_in);
      end
    end else if (ret) begin
      if (exp_q.size() == 0) m_unf = 1;
      else m_pc = int'(exp_q.pop_back());
    end else if (branch) begin
      m_pc = (m_pc + int'(offset)) % MODV;
    end else if (inc) begin
      m_pc = (m_pc + 1) % MODV;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_pc",    int'(data_out),    m_pc);
      chk("model_depth", int'(depth),       exp_q.size());
      chk("model_full",  int'(stack_full),  int'(exp_q.size() == DEPTH));
      chk("model_empty", int'(stack_empty), int'(exp_q.size() == 0));
      chk("model_ovf",   int'(ovf_err),     m_ovf);
      chk("model_unf",   int'(unf_err),     m_unf);
    end
  end

  // ---------------- driver ----------------
  // Called at a falling edge; applies inputs across one rising edge and
  // returns at the next falling edge with outputs settled.
  task automatic step(input logic [6:0] ctl, input int d = 0, input int o = 0);
    {clr, stall, load, call, ret, branch, inc} = ctl;
    data_in = AW'(d);
    offset  = AW'(o);
    @(negedge clk);
  endtask

  task automatic expect_pc(input string name, input int pc, input int dep);
    chk({name, "_pc"},    int'(data_out), pc);
    chk({name, "_depth"}, int'(depth),    dep);
  endtask

  initial begin
    @(negedge clk);

    // 1: reset then count
    step(C_CLR);
    expect_pc("reset", 0, 0);
    chk("reset_empty", int'(stack_empty), 1);
    chk("reset_ovf", int'(ovf_err), 0);
    chk("reset_unf", int'(unf_err), 0);
    step(C_INC); expect_pc("inc1", 1, 0);
    step(C_INC); expect_pc("inc2", 2, 0);
    step(C_INC); expect_pc("inc3", 3, 0);
    chk("inc_empty", int'(stack_empty), 1);

    // 2: load and wrap, load beats inc
    step(C_LOAD, 62); expect_pc("load62", 62, 0);
    step(C_INC);      expect_pc("wrap63", 63, 0);
    step(C_INC);      expect_pc("wrap0", 0, 0);
    step(C_LOAD | C_INC, 40); expect_pc("load_beats_inc", 40, 0);

    // 3: branches
    step(C_LOAD, 10);
    step(C_BRANCH, 0, 'h3C); expect_pc("branch_neg", 6, 0);
    step(C_BRANCH, 0, 5);    expect_pc("branch_pos", 11, 0);
    step(C_LOAD, 60);
    step(C_BRANCH, 0, 8);    expect_pc("branch_wrap", 4, 0);

    // 4: nested call/return
    step(C_LOAD, 5);
    step(C_CALL, 20); expect_pc("call20", 20, 1);
    step(C_CALL, 30); expect_pc("call30", 30, 2);
    step(C_RET);      expect_pc("ret1", 21, 1);
    step(C_RET);      expect_pc("ret2", 6, 0);

    // 5: overflow / underflow
    step(C_CLR);
    step(C_CALL, 1); step(C_CALL, 2); step(C_CALL, 3); step(C_CALL, 4);
    expect_pc("fill", 4, 4);
    chk("fill_full", int'(stack_full), 1);
    step(C_CALL, 9); expect_pc("ovf_hold", 4, 4);
    chk("ovf_set", int'(ovf_err), 1);
    step(C_RET); expect_pc("pop4", 4, 3);
    step(C_RET); expect_pc("pop3", 3, 2);
    step(C_RET); expect_pc("pop2", 2, 1);
    step(C_RET); expect_pc("pop1", 1, 0);
    step(C_RET); expect_pc("unf_hold", 1, 0);
    chk("unf_set", int'(unf_err), 1);
    chk("ovf_sticky", int'(ovf_err), 1);
    step(C_CALL, 7); expect_pc("call_after_err", 7, 1);
    chk("unf_sticky", int'(unf_err), 1);
    step(C_CLR);
    chk("ovf_clr", int'(ovf_err), 0);
    chk("unf_clr", int'(unf_err), 0);

    // 6: stall freezes, clr beats stall
    step(C_LOAD, 12);
    step(C_CALL, 20); expect_pc("pre_stall", 20, 1);
    for (int i = 0; i < 3; i++) begin
      step(C_STALL | C_INC | C_CALL | C_RET, 33, 3);
      expect_pc("stall", 20, 1);
    end
    step(C_CLR | C_STALL); expect_pc("clr_in_stall", 0, 0);

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] ctl;
      ctl[6] = ($urandom_range(0, 63) == 0);
      ctl[5] = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < 5; b++) ctl[b] = ($urandom_range(0, 2) == 0);
      step(ctl, int'($urandom_range(0, MODV - 1)), int'($urandom_range(0, MODV - 1)));
    end

    step(C_NONE);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
